// File: rtl/tb_result_merger.sv
// tb_result_merger: packs per-lane traceback symbols into words, buffers them per lane,
// and merges the lanes round-robin onto one lane-tagged valid/ready stream.
module tb_result_merger #(
    parameter int NUM_CH     = 4,
    parameter int BP_WIDTH   = 2,
    parameter int PACK       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W      = $clog2(PACK + 1)
) (
    input  logic                         clk,
    input  logic                         reset_i,
    input  logic [NUM_CH*BP_WIDTH-1:0]   aln_i,
    input  logic [NUM_CH-1:0]            aln_valid_i,
    input  logic [NUM_CH-1:0]            done_i,
    input  logic                         clear_i,
    output logic [PACK*BP_WIDTH-1:0]     out_data_o,
    output logic [CNT_W-1:0]             out_cnt_o,
    output logic [CH_W-1:0]              out_ch_o,
    output logic                         out_last_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NUM_CH-1:0]            ovf_o,
    output logic                         busy_o
);
    localparam int DW = PACK * BP_WIDTH;
    localparam int EW = DW + CNT_W + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0]         empty, pop, pending, ovf_set;
    logic [NUM_CH-1:0][EW-1:0] head;
    logic [CH_W-1:0]           rr, gnt;
    logic                      found, load;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [CNT_W-1:0] pcnt, wcnt;
        logic [DW-1:0]    pdata, wdata;
        logic [AW:0]      wptr, rptr;
        logic [EW-1:0]    mem [FIFO_DEPTH];
        logic             sym, push, full, accept;
        assign sym  = aln_valid_i[k];
        assign wcnt = pcnt + CNT_W'(sym);
        assign push = (sym && pcnt == CNT_W'(PACK - 1)) || done_i[k];
        always_comb begin
            wdata = pdata;
            if (sym)
                wdata[pcnt*BP_WIDTH +: BP_WIDTH] = aln_i[k*BP_WIDTH +: BP_WIDTH];
        end
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        assign full        = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
        assign empty[k]    = wptr == rptr;
        assign accept      = push && (!full || pop[k]);
        assign ovf_set[k]  = push && full && !pop[k];
        assign head[k]     = mem[rptr[AW-1:0]];
        assign pending[k]  = pcnt != '0;
        always_ff @(posedge clk or posedge reset_i) begin
            if (reset_i) begin
                pcnt  <= '0;
                pdata <= '0;
                wptr  <= '0;
                rptr  <= '0;
            end else begin
                pcnt  <= push ? '0 : wcnt;
                pdata <= push ? '0 : wdata;
                if (accept) wptr <= wptr + 1'b1;
                if (pop[k]) rptr <= rptr + 1'b1;
            end
        end
        always_ff @(posedge clk)
            if (accept) mem[wptr[AW-1:0]] <= {wdata, wcnt, done_i[k]};
    end

    // Lowest offset from rr wins; scanning downward lets it overwrite the others.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!empty[(int'(rr) + i) % NUM_CH]) begin
                found = 1'b1;
                gnt   = CH_W'((int'(rr) + i) % NUM_CH);
            end
        end
    end

    assign load   = !out_valid_o || out_ready_i;
    assign pop    = (load && found) ? (NUM_CH'(1) << gnt) : '0;
    assign busy_o = (|pending) || !(&empty) || out_valid_o;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rr          <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_cnt_o   <= '0;
            out_ch_o    <= '0;
            out_last_o  <= 1'b0;
            ovf_o       <= '0;
        end else begin
            ovf_o <= (ovf_o & ~{NUM_CH{clear_i}}) | ovf_set;
            if (load) begin
                out_valid_o <= found;
                if (found) begin
                    {out_data_o, out_cnt_o, out_last_o} <= head[gnt];
                    out_ch_o <= gnt;
                    rr       <= CH_W'((int'(gnt) + 1) % NUM_CH);
                end
            end
        end
    end
endmodule

// File: tb/tb_tb_result_merger.sv
// tb_tb_result_merger: randomized and directed scoreboard bench for tb_result_merger.
module tb_tb_result_merger;
    localparam int NUM_CH = 4, BPW = 2, PACK = 16, DEPTH = 8;
    localparam int CH_W = 2, CNT_W = 5, DW = PACK * BPW, AWID = NUM_CH * BPW;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [CNT_W-1:0] cnt;
        logic             last;
    } word_t;

    logic              clk = 0, reset_i = 1, clear_i = 0, out_ready_i = 0;
    logic [AWID-1:0]   aln_i = '0;
    logic [NUM_CH-1:0] aln_valid_i = '0, done_i = '0;
    logic [DW-1:0]     out_data_o;
    logic [CNT_W-1:0]  out_cnt_o;
    logic [CH_W-1:0]   out_ch_o;
    logic              out_last_o, out_valid_o, busy_o;
    logic [NUM_CH-1:0] ovf_o;

    int vectors = 0, miscompares = 0;
    logic [BPW-1:0] acc [NUM_CH][$];
    word_t          exp_q [NUM_CH][$];
    int             ch_log [$];
    logic [NUM_CH-1:0] drop = '0;

    tb_result_merger #(.NUM_CH(NUM_CH), .BP_WIDTH(BPW), .PACK(PACK), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_i(reset_i), .aln_i(aln_i), .aln_valid_i(aln_valid_i),
        .done_i(done_i), .clear_i(clear_i), .out_data_o(out_data_o), .out_cnt_o(out_cnt_o),
        .out_ch_o(out_ch_o), .out_last_o(out_last_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .ovf_o(ovf_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a lane's symbols form a word once PACK have gathered or done arrives.
    task automatic drive(input logic [NUM_CH-1:0] v, input logic [AWID-1:0] a,
                         input logic [NUM_CH-1:0] d);
        aln_i = a; aln_valid_i = v; done_i = d;
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[k]) acc[k].push_back(a[k*BPW +: BPW]);
            if (acc[k].size() == PACK || d[k]) begin
                word_t w;
                w.data = '0;
                for (int i = 0; i < acc[k].size(); i++) w.data[i*BPW +: BPW] = acc[k][i];
                w.cnt  = CNT_W'(acc[k].size());
                w.last = d[k];
                if (!drop[k]) exp_q[k].push_back(w);
                acc[k].delete();
            end
        end
        @(posedge clk); #1;
        aln_valid_i = '0; done_i = '0; clear_i = 0;
    endtask

    task automatic push_word(input int lane, input int n);
        for (int i = 0; i < n; i++)
            drive(NUM_CH'(1) << lane, AWID'($urandom), (i == n - 1) ? (NUM_CH'(1) << lane) : '0);
    endtask

    task automatic wait_idle();
        out_ready_i = 1;
        for (int i = 0; i < 300 && busy_o; i++) drive('0, '0, '0);
        if (busy_o) chk("idle_timeout", 64'(busy_o), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset_i && out_valid_o && out_ready_i) begin
            int ch;
            word_t w;
            ch = int'(out_ch_o);
            ch_log.push_back(ch);
            vectors++;
            if (exp_q[ch].size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word ch=%0d cnt=%0d data=%0h", ch, out_cnt_o, out_data_o);
            end else begin
                w = exp_q[ch].pop_front();
                if (out_data_o !== w.data || out_cnt_o !== w.cnt || out_last_o !== w.last) begin
                    miscompares++;
                    $display("FAIL word ch=%0d: got data=%0h cnt=%0d last=%0b expected data=%0h cnt=%0d last=%0b",
                             ch, out_data_o, out_cnt_o, out_last_o, w.data, w.cnt, w.last);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_i = 0;
        chk("rst_valid", 64'(out_valid_o), 0);
        chk("rst_ovf", 64'(ovf_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_cnt", 64'(out_cnt_o), 0);

        // Simultaneous bursts from all lanes: rr starts at 0 and wraps back to 0.
        out_ready_i = 1;
        ch_log.delete();
        drive('1, AWID'($urandom), '1);
        wait_idle();
        drive('1, AWID'($urandom), '1);
        wait_idle();
        chk("rr_log_size", 64'(ch_log.size()), 8);
        for (int i = 0; i < 8 && i < ch_log.size(); i++)
            chk($sformatf("rr_order%0d", i), 64'(ch_log[i]), 64'(i % NUM_CH));

        // 16 symbols 0,1,2,3,... then done: full word then empty last word.
        for (int i = 0; i < PACK; i++) drive(4'b0001, AWID'(i % 4), '0);
        chk("lat_not_yet", 64'(out_valid_o), 0);
        drive('0, '0, 4'b0001);
        chk("lat_valid", 64'(out_valid_o), 1);
        chk("lat_cnt", 64'(out_cnt_o), PACK);
        chk("lat_ch", 64'(out_ch_o), 0);
        wait_idle();

        // Five symbols with done on the fifth.
        push_word(0, 5);
        wait_idle();

        // Overflow: lane 2, ready low, ten pushes; the tenth is dropped.
        out_ready_i = 0;
        for (int j = 0; j < 9; j++) push_word(2, 1);
        chk("ovf_before", 64'(ovf_o[2]), 0);
        drop[2] = 1;
        push_word(2, 1);
        drop[2] = 0;
        chk("ovf_set", 64'(ovf_o[2]), 1);
        wait_idle();
        chk("ovf_sticky", 64'(ovf_o), 64'(4'b0100));
        clear_i = 1;
        drive('0, '0, '0);
        chk("ovf_clear", 64'(ovf_o), 0);

        // Full FIFO with a pop and push on the same edge: nothing lost.
        out_ready_i = 0;
        for (int j = 0; j < 9; j++) push_word(1, (j % 7) + 1);
        drive(4'b0010, AWID'($urandom), '0);
        drive(4'b0010, AWID'($urandom), '0);
        out_ready_i = 1;
        drive(4'b0010, AWID'($urandom), 4'b0010);
        chk("full_pop_push_ovf", 64'(ovf_o), 0);
        wait_idle();

        // Asynchronous reset with buffered words and a set overflow flag.
        out_ready_i = 0;
        for (int j = 0; j < 10; j++) begin
            drop[3] = (j == 9);
            push_word(3, 2);
        end
        drop[3] = 0;
        chk("pre_rst_ovf", 64'(ovf_o[3]), 1);
        chk("pre_rst_valid", 64'(out_valid_o), 1);
        #2 reset_i = 1;
        #1;
        chk("arst_valid", 64'(out_valid_o), 0);
        chk("arst_ovf", 64'(ovf_o), 0);
        chk("arst_busy", 64'(busy_o), 0);
        chk("arst_data", 64'(out_data_o), 0);
        for (int k = 0; k < NUM_CH; k++) begin
            acc[k].delete();
            exp_q[k].delete();
        end
        @(posedge clk); #3 reset_i = 0;
        @(posedge clk); #1;
        out_ready_i = 1;
        repeat (10) drive('0, '0, '0);
        chk("post_rst_valid", 64'(out_valid_o), 0);

        // Random traffic at a rate the lane FIFOs can absorb.
        for (int c = 0; c < 600; c++) begin
            logic [NUM_CH-1:0] v, d;
            v = NUM_CH'($urandom);
            for (int k = 0; k < NUM_CH; k++) d[k] = ($urandom % 16) == 0;
            out_ready_i = ($urandom % 4) != 0;
            drive(v, AWID'($urandom), d);
        end
        drive('0, '0, '1);
        wait_idle();
        for (int k = 0; k < NUM_CH; k++)
            chk($sformatf("drain_lane%0d", k), 64'(exp_q[k].size()), 0);
        chk("rand_ovf", 64'(ovf_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tb_result_merger.md
# tb_result_merger

Parametrised successor to the single-lane alignment top-level output path. It collects traceback symbol streams (`alignment_out`/`alignment_valid`/`done`) from `NUM_CH` independent DP+traceback lanes, packs each lane's symbols into `PACK`-symbol words, buffers them in per-lane FIFOs, and merges them round-robin onto one valid/ready host stream tagged with lane ID. It sits between the traceback engines and the host interface, replacing direct per-lane `alignment_out` wiring.

## Interface
- `NUM_CH`, 4, number of traceback lanes (≥1).
- `BP_WIDTH`, 2, bits per alignment symbol (matches `` `BP_WIDTH``).
- `PACK`, 16, symbols per output word (≥2).
- `FIFO_DEPTH`, 8, words per lane FIFO (power of two, ≥2).
- `CH_W`, max(1,$clog2(NUM_CH)), lane-ID width (derived).
- `CNT_W`, $clog2(PACK+1), symbol-count width (derived).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `aln_i`  in  NUM_CH*BP_WIDTH  lane k symbol at bits [k*BP_WIDTH +: BP_WIDTH].
- `aln_valid_i`  in  NUM_CH  lane k symbol valid, one symbol per cycle.
- `done_i`  in  NUM_CH  lane k traceback finished (1-cycle pulse).
- `clear_i`  in  1  synchronous clear of overflow flags.
- `out_data_o`  out  PACK*BP_WIDTH  packed symbols; first symbol in LSBs.
- `out_cnt_o`  out  CNT_W  valid symbols in word (0..PACK).
- `out_ch_o`  out  CH_W  source lane.
- `out_last_o`  out  1  final word of that lane's alignment.
- `out_valid_o`  out  1  word valid.
- `out_ready_i`  in  1  host accepts word.
- `ovf_o`  out  NUM_CH  sticky per-lane FIFO-overflow flag.
- `busy_o`  out  1  any packer holds symbols or any FIFO/output register non-empty.

## Operation
- Per-lane packer: shift register + count `pcnt` (0..PACK-1). Symbol on `aln_valid_i[k]` written at slot `pcnt`, `pcnt++`.
- Word push (to lane FIFO) when: (a) symbol makes PACK symbols -> cnt=PACK, last=`done_i[k]` of same cycle; (b) `done_i[k]` with no completing symbol -> cnt=`pcnt`(+1 if symbol in same cycle), last=1. `done_i` with `pcnt`=0 and no symbol pushes an empty word cnt=0,last=1. After push `pcnt`=0; unused slots of data zero.
- FIFO entry = {data, cnt, last}. Push to full FIFO: word dropped, `ovf_o[k]` set (same edge), packer still resets. Traceback lanes cannot be stalled; no backpressure to lanes.
- `ovf_o` cleared only by `clear_i` (or reset); `clear_i` coincident with new overflow -> flag stays 1.
- Arbiter: round-robin pointer `rr`. Output register loads when empty or being consumed (`out_valid_o & out_ready_i`). Grant = first non-empty lane scanning `rr, rr+1, ... mod NUM_CH`; on grant, pop that FIFO, `rr` <- grant+1 mod NUM_CH. No grant -> `rr` unchanged.
- Output register holds data/cnt/ch/last stable while `out_valid_o & !out_ready_i`.
- Words of one lane leave in push order; lanes interleave word-by-word.

## Timing
- Reset: all outputs 0 (`out_valid_o`=0, `ovf_o`=0, `busy_o`=0), packers/FIFOs empty, `rr`=0. Reset mid-operation discards all buffered data immediately.
- Latency: push at edge E; word visible on outputs after edge E+1 if output register free and lane wins arbitration; minimum symbol-to-output latency 2 cycles.
- Same-cycle push and pop on one FIFO allowed, including when full (pop frees slot first: no overflow) and when empty (no bypass; word emerges next cycle).
- Throughput: one output word per cycle with `out_ready_i` held 1.
- `busy_o` combinational from state, no lag.

## Test plan
- Single lane, PACK=16: 16 symbols 0,1,2,3,... on lane 0, then `done_i` -> one word cnt=16, last=0, data LSB symbol 0; then empty word cnt=0,last=1, ch=0.
- Symbol plus `done_i` same cycle after 4 symbols (5 total) -> one word cnt=5,last=1, upper 11 slots zero.
- All 4 lanes push a word the same cycle, ready=1 -> outputs ch 0,1,2,3 on consecutive cycles; next simultaneous burst starts at ch 0 again (rr wrapped).
- Ready held 0, lane 2 pushes 10 words (DEPTH=8, plus 1 in output register) -> `ovf_o[2]`=1 on 10th push, 9 words delivered in order after ready=1; `clear_i` -> `ovf_o`=0.
- Full FIFO with simultaneous pop and push -> no overflow, order preserved.
- Assert `reset_i` with words buffered and `out_valid_o`=1 -> all outputs 0 asynchronously, nothing emitted after release.
